jts16_obj_sched: RTL

- Per-scanline sprite scheduler for the object draw engine.
- On each hstart it walks the object attribute table from entry 0 and selects the sprites that cover the line being rendered.
- For each selected sprite it computes the ROM word offset for that line and issues one start/busy job to the draw engine.
- Sits between the object attribute RAM (1-cycle read latency) and the draw engine; one instance per object layer.

---
 rtl/jts16_obj_sched_if.sv | 24 ++
 rtl/jts16_obj_sched.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/jts16_obj_sched_if.sv
// Attribute-RAM read port and draw-engine job bus shared by the object scheduler and its peers.
interface jts16_obj_sched_if;
  logic [9:0]  tbl_addr;
  logic [15:0] tbl_dout;
  logic        dr_start;
  logic        dr_busy;
  logic [8:0]  dr_xpos;
  logic [15:0] dr_offset;
  logic [3:0]  dr_bank;
  logic [1:0]  dr_prio;
  logic [5:0]  dr_pal;
  logic [4:0]  dr_hzoom;
  logic        dr_hflip;

  modport master (
    output tbl_addr, dr_start, dr_xpos, dr_offset, dr_bank, dr_prio, dr_pal, dr_hzoom, dr_hflip,
    input  tbl_dout, dr_busy
  );

  modport slave (
    input  tbl_addr, dr_start, dr_xpos, dr_offset, dr_bank, dr_prio, dr_pal, dr_hzoom, dr_hflip,
    output tbl_dout, dr_busy
  );
endinterface

// File: rtl/jts16_obj_sched.sv
// Per-scanline sprite scheduler: walks the object table on hstart and issues one draw job per visible sprite.
module jts16_obj_sched #(
  parameter int unsigned MODEL   = 0,
  parameter int unsigned ENTRIES = 128
) (
  input  logic                  rst,
  input  logic                  clk,
  input  logic                  hstart_i,
  input  logic [8:0]            vrender_i,
  output logic                  done_o,
  jts16_obj_sched_if.master     bus
);

  typedef enum logic [3:0] {
    IDLE, RD0, RD1, RD2, RD3, RD4, RD5, CHECK, CALC, ISSUE, WAIT, NEXT
  } state_t;

  localparam logic [6:0] LAST_ENTRY = 7'(ENTRIES - 1);

  state_t      state_q;
  logic [6:0]  entry_q;
  logic [8:0]  line_q;
  logic [9:0]  tbl_addr_q;
  logic        done_q;
  logic        wait_first_q;
  logic [7:0]  top_q, bot_q;
  logic [8:0]  xpos_q;
  logic [15:0] pitch_q, base_q;
  logic [1:0]  prio_q;
  logic [3:0]  bank_q;
  logic [5:0]  pal_q;
  logic        hflip_q;
  logic [4:0]  hzoom_q;

  logic        dr_start_q;
  logic [8:0]  dr_xpos_q;
  logic [15:0] dr_offset_q;
  logic [3:0]  dr_bank_q;
  logic [1:0]  dr_prio_q;
  logic [5:0]  dr_pal_q;
  logic [4:0]  dr_hzoom_q;
  logic        dr_hflip_q;

  logic [7:0]  rows;
  logic [15:0] rows_p1;
  logic [15:0] offset_d;
  logic [6:0]  entry_nx;
  logic        hit;

  always_comb begin
    rows     = line_q[7:0] - top_q;
    rows_p1  = {8'd0, rows} + 16'd1;
    offset_d = base_q + pitch_q * rows_p1;
    entry_nx = entry_q + 7'd1;
    hit      = ({1'b0, top_q} <= line_q) && (line_q < {1'b0, bot_q});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      entry_q      <= '0;
      line_q       <= '0;
      tbl_addr_q   <= '0;
      done_q       <= 1'b1;
      wait_first_q <= 1'b0;
      top_q        <= '0;
      bot_q        <= '0;
      xpos_q       <= '0;
      pitch_q      <= '0;
      base_q       <= '0;
      prio_q       <= '0;
      bank_q       <= '0;
      pal_q        <= '0;
      hflip_q      <= 1'b0;
      hzoom_q      <= '0;
      dr_start_q   <= 1'b0;
      dr_xpos_q    <= '0;
      dr_offset_q  <= '0;
      dr_bank_q    <= '0;
      dr_prio_q    <= '0;
      dr_pal_q     <= '0;
      dr_hzoom_q   <= '0;
      dr_hflip_q   <= 1'b0;
    end else if (hstart_i) begin
      line_q     <= vrender_i;
      entry_q    <= '0;
      done_q     <= 1'b0;
      dr_start_q <= 1'b0;
      tbl_addr_q <= '0;
      state_q    <= RD0;
    end else begin
      case (state_q)
        IDLE: ;
        RD0: begin
          tbl_addr_q <= {entry_q, 3'd1};
          state_q    <= RD1;
        end
        RD1: begin
          {bot_q, top_q} <= bus.tbl_dout;
          tbl_addr_q     <= {entry_q, 3'd2};
          state_q        <= RD2;
        end
        RD2: begin
          xpos_q     <= bus.tbl_dout[8:0];
          tbl_addr_q <= {entry_q, 3'd3};
          state_q    <= RD3;
        end
        RD3: begin
          pitch_q    <= bus.tbl_dout;
          tbl_addr_q <= {entry_q, 3'd4};
          state_q    <= RD4;
        end
        RD4: begin
          base_q     <= bus.tbl_dout;
          tbl_addr_q <= {entry_q, 3'd5};
          state_q    <= RD5;
        end
        RD5: begin
          prio_q  <= bus.tbl_dout[13:12];
          bank_q  <= bus.tbl_dout[11:8];
          pal_q   <= bus.tbl_dout[5:0];
          state_q <= CHECK;
        end
        CHECK: begin
          // Word 5 lands here; the decision needs only word 0, so the last capture overlaps it.
          hflip_q <= bus.tbl_dout[8];
          hzoom_q <= bus.tbl_dout[4:0];
          if (top_q == 8'hFF) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else if (hit) begin
            state_q <= CALC;
          end else begin
            state_q <= NEXT;
          end
        end
        CALC: begin
          dr_offset_q <= offset_d;
          dr_xpos_q   <= xpos_q;
          dr_bank_q   <= bank_q;
          dr_prio_q   <= prio_q;
          dr_pal_q    <= pal_q;
          dr_hzoom_q  <= hzoom_q;
          dr_hflip_q  <= (MODEL == 1) ? hflip_q : 1'b0;
          state_q     <= ISSUE;
        end
        ISSUE: begin
          if (!bus.dr_busy) begin
            dr_start_q   <= 1'b1;
            wait_first_q <= 1'b1;
            state_q      <= WAIT;
          end
        end
        WAIT: begin
          dr_start_q <= 1'b0;
          if (wait_first_q) begin
            wait_first_q <= 1'b0;
          end else if (!bus.dr_busy) begin
            state_q <= NEXT;
          end
        end
        NEXT: begin
          if (entry_q == LAST_ENTRY) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            entry_q    <= entry_nx;
            tbl_addr_q <= {entry_nx, 3'd0};
            state_q    <= RD0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tbl_addr  = tbl_addr_q;
  assign bus.dr_start  = dr_start_q;
  assign bus.dr_xpos   = dr_xpos_q;
  assign bus.dr_offset = dr_offset_q;
  assign bus.dr_bank   = dr_bank_q;
  assign bus.dr_prio   = dr_prio_q;
  assign bus.dr_pal    = dr_pal_q;
  assign bus.dr_hzoom  = dr_hzoom_q;
  assign bus.dr_hflip  = dr_hflip_q;
  assign done_o        = done_q;

endmodule
